// File: rtl/wts_ram_pkg.sv
// rtl/wts_ram_pkg.sv - shared constants and types for the wave table sample RAM
package wts_ram_pkg;

  localparam int WTS_RAM_DEPTH = 384;
  localparam int WTS_RAM_AW    = 9;
  localparam int WTS_RAM_DW    = 8;

  typedef logic [WTS_RAM_AW-1:0] wts_ram_addr_t;
  typedef logic [WTS_RAM_DW-1:0] wts_ram_data_t;

  function automatic logic wts_ram_in_range(input wts_ram_addr_t a);
    return a < wts_ram_addr_t'(WTS_RAM_DEPTH);
  endfunction

endpackage

// File: rtl/wts_ram_clear.sv
// rtl/wts_ram_clear.sv - post-reset clear sequencer, one address per cycle
// Used only when WTS_RAM_CLEAR_EN is defined.
module wts_ram_clear
  import wts_ram_pkg::*;
(
  input  logic          clk,
  input  logic          nreset,
  output logic          busy,
  output wts_ram_addr_t addr
);

  localparam wts_ram_addr_t LAST_ADDR = wts_ram_addr_t'(WTS_RAM_DEPTH - 1);

  // Busy comes up set out of reset, so the first edge after release clears address 0.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      busy <= 1'b1;
      addr <= '0;
    end else if (busy) begin
      if (addr == LAST_ADDR) begin
        busy <= 1'b0;
      end
      addr <= addr + wts_ram_addr_t'(1);
    end
  end

endmodule

// File: rtl/wts_wave_ram.sv
// rtl/wts_wave_ram.sv - 384 x 8 single-port waveform RAM, registered read, read-first
// Optional post-reset zero fill when WTS_RAM_CLEAR_EN is defined.
module wts_wave_ram
  import wts_ram_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic       sram_we,
  input  logic [8:0] sram_a,
  input  logic [7:0] sram_d,
  output logic [7:0] sram_q
);

  wts_ram_data_t mem [0:WTS_RAM_DEPTH-1];

  logic          clr_busy;
  logic          wr_en;
  wts_ram_addr_t wr_a;
  wts_ram_data_t wr_d;
  logic          rd_zero;

`ifdef WTS_RAM_CLEAR_EN
  wts_ram_addr_t clr_addr;

  wts_ram_clear u_clear (
    .clk    (clk),
    .nreset (nreset),
    .busy   (clr_busy),
    .addr   (clr_addr)
  );

  assign wr_en = clr_busy ? 1'b1     : (sram_we && wts_ram_in_range(sram_a));
  assign wr_a  = clr_busy ? clr_addr : sram_a;
  assign wr_d  = clr_busy ? '0       : sram_d;
`else
  assign clr_busy = 1'b0;
  assign wr_en    = sram_we && wts_ram_in_range(sram_a);
  assign wr_a     = sram_a;
  assign wr_d     = sram_d;
`endif

  assign rd_zero = clr_busy || !wts_ram_in_range(sram_a);

  // No reset on the array so it stays a plain block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_a] <= wr_d;
    end
  end

  // Reads the pre-write contents on a same-address write (read-first).
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sram_q <= '0;
    end else if (rd_zero) begin
      sram_q <= '0;
    end else begin
      sram_q <= mem[sram_a];
    end
  end

endmodule

// File: tb/tb_wts_wave_ram.sv
// tb/tb_wts_wave_ram.sv - directed self-checking bench for wts_wave_ram
// Also covers the clear sequencer when built with WTS_RAM_CLEAR_EN.
module tb_wts_wave_ram;

  logic       clk;
  logic       nreset;
  logic       sram_we;
  logic [8:0] sram_a;
  logic [7:0] sram_d;
  logic [7:0] sram_q;

  logic [7:0] exp_mem [0:383];
  int checks;
  int errors;

  wts_wave_ram dut (
    .clk     (clk),
    .nreset  (nreset),
    .sram_we (sram_we),
    .sram_a  (sram_a),
    .sram_d  (sram_d),
    .sram_q  (sram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; applies one access and returns at the next negedge.
  task automatic op(input logic we, input logic [8:0] a, input logic [7:0] d);
    sram_we = we;
    sram_a  = a;
    sram_d  = d;
    @(negedge clk);
    sram_we = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    nreset = 1'b1;
`ifdef WTS_RAM_CLEAR_EN
    repeat (384) @(negedge clk);
    for (int i = 0; i < 384; i++) exp_mem[i] = 8'h00;
`endif
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (sram_q !== 8'h00) begin
      errors++;
      $display("FAIL reset_initial got=%h exp=00", sram_q);
    end
    release_reset();
    op(1'b1, 9'd10, 8'h5A);
    exp_mem[10] = 8'h5A;
    op(1'b0, 9'd10, 8'h00);
    checks++;
    if (sram_q !== 8'h5A) begin
      errors++;
      $display("FAIL reset_pre_value got=%h exp=5a", sram_q);
    end
    sram_a = 9'd10;
    #2;
    nreset = 1'b0;
    #1;
    checks++;
    if (sram_q !== 8'h00) begin
      errors++;
      $display("FAIL reset_async got=%h exp=00", sram_q);
    end
    @(negedge clk);
    checks++;
    if (sram_q !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold got=%h exp=00", sram_q);
    end
    nreset = 1'b1;
    #2;
    checks++;
    if (sram_q !== 8'h00) begin
      errors++;
      $display("FAIL reset_before_first_edge got=%h exp=00", sram_q);
    end
    @(negedge clk);
`ifdef WTS_RAM_CLEAR_EN
    repeat (383) @(negedge clk);
    for (int i = 0; i < 384; i++) exp_mem[i] = 8'h00;
`else
    checks++;
    if (sram_q !== 8'h5A) begin
      errors++;
      $display("FAIL reset_first_read got=%h exp=5a", sram_q);
    end
`endif
  endtask

  task automatic test_fill();
    for (int i = 0; i < 384; i++) begin
      op(1'b1, 9'(i), 8'((i + 100) & 8'hFF));
      exp_mem[i] = 8'((i + 100) & 8'hFF);
    end
    for (int i = 0; i < 384; i++) begin
      op(1'b0, 9'(i), 8'h00);
      checks++;
      if (sram_q !== 8'((i + 100) & 8'hFF)) begin
        errors++;
        $display("FAIL fill_read addr=%0d got=%h exp=%h", i, sram_q, 8'((i + 100) & 8'hFF));
      end
    end
  endtask

  task automatic test_read_first();
    op(1'b1, 9'd7, 8'h11);
    op(1'b1, 9'd7, 8'h22);
    checks++;
    if (sram_q !== 8'h11) begin
      errors++;
      $display("FAIL read_first_old got=%h exp=11", sram_q);
    end
    op(1'b0, 9'd7, 8'h00);
    checks++;
    if (sram_q !== 8'h22) begin
      errors++;
      $display("FAIL read_first_new got=%h exp=22", sram_q);
    end
    exp_mem[7] = 8'h22;
  endtask

  task automatic test_back_to_back();
    op(1'b1, 9'd50, 8'h3C);
    op(1'b0, 9'd50, 8'h00);
    checks++;
    if (sram_q !== 8'h3C) begin
      errors++;
      $display("FAIL b2b_50 got=%h exp=3c", sram_q);
    end
    op(1'b1, 9'd383, 8'hC3);
    op(1'b0, 9'd383, 8'h00);
    checks++;
    if (sram_q !== 8'hC3) begin
      errors++;
      $display("FAIL b2b_383 got=%h exp=c3", sram_q);
    end
    exp_mem[50]  = 8'h3C;
    exp_mem[383] = 8'hC3;
  endtask

  task automatic test_out_of_range();
    op(1'b1, 9'd384, 8'hAA);
    op(1'b1, 9'd511, 8'hAA);
    op(1'b0, 9'd0, 8'h00);
    checks++;
    if (sram_q !== exp_mem[0]) begin
      errors++;
      $display("FAIL oor_addr0 got=%h exp=%h", sram_q, exp_mem[0]);
    end
    op(1'b0, 9'd127, 8'h00);
    checks++;
    if (sram_q !== exp_mem[127]) begin
      errors++;
      $display("FAIL oor_addr127 got=%h exp=%h", sram_q, exp_mem[127]);
    end
    op(1'b0, 9'd384, 8'h00);
    checks++;
    if (sram_q !== 8'h00) begin
      errors++;
      $display("FAIL oor_read384 got=%h exp=00", sram_q);
    end
    op(1'b0, 9'd383, 8'h00);
    op(1'b0, 9'd511, 8'h00);
    checks++;
    if (sram_q !== 8'h00) begin
      errors++;
      $display("FAIL oor_read511 got=%h exp=00", sram_q);
    end
  endtask

  task automatic test_no_write();
    for (int i = 0; i < 384; i++) begin
      op(1'b0, 9'(i), 8'($urandom));
    end
    for (int i = 0; i < 384; i++) begin
      op(1'b0, 9'(i), 8'($urandom));
      checks++;
      if (sram_q !== exp_mem[i]) begin
        errors++;
        $display("FAIL no_write addr=%0d got=%h exp=%h", i, sram_q, exp_mem[i]);
      end
    end
  endtask

`ifdef WTS_RAM_CLEAR_EN
  task automatic test_clear();
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 384; i++) begin
      op(1'b1, 9'(i), 8'hFF);
      checks++;
      if (sram_q !== 8'h00) begin
        errors++;
        $display("FAIL clear_busy_q cycle=%0d got=%h exp=00", i, sram_q);
      end
    end
    for (int i = 0; i < 384; i++) begin
      op(1'b0, 9'(i), 8'h00);
      checks++;
      if (sram_q !== 8'h00) begin
        errors++;
        $display("FAIL clear_contents addr=%0d got=%h exp=00", i, sram_q);
      end
      exp_mem[i] = 8'h00;
    end
  endtask
`endif

  initial begin
    checks  = 0;
    errors  = 0;
    nreset  = 1'b0;
    sram_we = 1'b0;
    sram_a  = '0;
    sram_d  = '0;
    for (int i = 0; i < 384; i++) exp_mem[i] = 8'h00;
    test_reset();
`ifdef WTS_RAM_CLEAR_EN
    test_clear();
`endif
    test_fill();
    test_read_first();
    test_back_to_back();
    test_out_of_range();
    test_no_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
